ifetch_unit: RTL



---
 rtl/ifetch_pkg.sv | 27 ++
 rtl/ifetch_unit_fifo.sv | 65 ++++++
 rtl/ifetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// +-----------------------------------------------------------------------------+
// | ifetch_pkg: shared types and constants for the instruction-fetch unit.      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package ifetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;
  localparam int              PC_STEP  = 4;

endpackage

`default_nettype wire

// File: rtl/ifetch_unit_fifo.sv
// +-----------------------------------------------------------------------------+
// | fetch_fifo: synchronous FIFO of fetch entries with flush, count and flags.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// +-----------------------------------------------------------------------------+
// | ifetch_unit: credit-limited in-order instruction fetch with redirect flush. |
// | Optional macro IFETCH_PERF_EN enables delivered/stall performance counters. |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int               WIDTH           = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC        = '0,
  parameter int               FIFO_DEPTH      = 2,
  parameter int               MAX_OUTSTANDING = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-3:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_stall
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e   r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_rsp_pc;
  logic [OW-1:0]  r_outstanding;

  logic [CW-1:0]  w_fifo_count;
  logic           w_fifo_empty;
  logic           w_fifo_full;
  fetch_entry_t   w_head;
  fetch_entry_t   w_wentry;
  logic           w_req_fire;
  logic           w_rsp_ok;
  logic           w_push;
  logic           w_pop;
  logic [OW-1:0]  w_out_next;
  logic [WIDTH-1:0] w_redir_pc;

  assign imem_req_valid = (r_state == RUN) && !redirect_valid
                       && ((32'(r_outstanding) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH))
                       && (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
  assign imem_addr      = r_pc[WIDTH-1:2];

  assign w_req_fire = imem_req_valid && imem_req_ready;
  // A zero-latency memory answers in the acceptance cycle, so that request counts as in flight.
  assign w_rsp_ok   = imem_rsp_valid && ((r_outstanding != '0) || w_req_fire);
  assign w_out_next = r_outstanding + OW'(w_req_fire) - OW'(w_rsp_ok);
  assign w_redir_pc = {redirect_pc[WIDTH-1:2], 2'b00};

  assign w_push        = (r_state == RUN) && !redirect_valid && w_rsp_ok;
  assign w_pop         = inst_valid && inst_ready;
  assign w_wentry.pc   = r_rsp_pc;
  assign w_wentry.inst = imem_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
    end else begin
      r_outstanding <= w_out_next;
      unique case (r_state)
        BOOT: begin
          r_state <= RUN;
          if (redirect_valid) begin
            r_pc     <= w_redir_pc;
            r_rsp_pc <= w_redir_pc;
          end
        end
        RUN, FLUSH: begin
          if (redirect_valid) begin
            r_pc     <= w_redir_pc;
            r_rsp_pc <= w_redir_pc;
            r_state  <= (w_out_next != '0) ? FLUSH : RUN;
          end else if (r_state == RUN) begin
            if (w_req_fire) r_pc     <= r_pc + WIDTH'(PC_STEP);
            if (w_rsp_ok)   r_rsp_pc <= r_rsp_pc + WIDTH'(PC_STEP);
          end else if (w_out_next == '0) begin
            r_state <= RUN;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .wdata (w_wentry),
    .rdata (w_head),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign inst_valid = !w_fifo_empty;
  assign inst_data  = w_fifo_empty ? '0 : w_head.inst;
  assign inst_pc    = w_fifo_empty ? '0 : w_head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop)                    r_perf_fetched <= r_perf_fetched + 32'd1;
      if (inst_ready && !inst_valid) r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((r_outstanding != '0) || w_req_fire));

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (!w_fifo_full || w_pop));

endmodule

`default_nettype wire
